// File: rtl/prng_pkg.sv
// Shared encodings and constants for the prng state controller.
// Seed floors are powers of two, so OR-ing lifts a word to its minimum.
package prng_pkg;

  localparam logic [1:0] OP_SAVE    = 2'd0;
  localparam logic [1:0] OP_RESTORE = 2'd1;
  localparam logic [1:0] OP_RESEED  = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  localparam logic [31:0] C1 = 32'h9E37_79B9;
  localparam logic [31:0] C2 = 32'h7F4A_7C15;

  localparam logic [31:0] S0_MIN = 32'd2;
  localparam logic [31:0] S1_MIN = 32'd8;
  localparam logic [31:0] S2_MIN = 32'd16;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_S0   = 2'd1;
  localparam logic [1:0] WR_S1   = 2'd2;
  localparam logic [1:0] WR_S2   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_CHECK,
    ST_RESP
  } state_e;

  function automatic logic [31:0] floor_word(
    input logic [31:0] w,
    input logic [31:0] min
  );
    return (w < min) ? (w | min) : w;
  endfunction

endpackage

// File: rtl/prng_state_ctrl_if.sv
// Host command/response handshake bundle for prng_state_ctrl.
// The master is the host register bus; the slave is the controller.
interface prng_state_ctrl_if #(
  parameter int SLOT_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SLOT_W-1:0] cmd_slot;
  logic [31:0]       cmd_seed;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic              rsp_ok;

  modport master (
    output cmd_valid, cmd_op, cmd_slot, cmd_seed,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_ok
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_slot, cmd_seed,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_ok
  );
endinterface

// File: rtl/prng_seed_expand.sv
// Expands a 32-bit seed into {s2,s1,s0}, each lifted above its
// minimum so the generator never starts from a degenerate state.
module prng_seed_expand
  import prng_pkg::*;
(
  input  logic [31:0] seed,
  output logic [95:0] words
);
  logic [31:0] d0, d1, d2;

  always_comb begin
    d0 = floor_word(seed, S0_MIN);
    d1 = floor_word(seed ^ C1, S1_MIN);
    d2 = floor_word(seed ^ C2, S2_MIN);
    words = {d2, d1, d0};
  end
endmodule

// File: rtl/prng_state_ctrl.sv
// Writer-side controller for the prng state port: save, restore
// and reseed with a read-back check after every write sequence.
module prng_state_ctrl
  import prng_pkg::*;
#(
  parameter int NSLOTS = 4,
  parameter int SLOT_W = 2
) (
  input  logic          clk,
  input  logic          resetn,
  prng_state_ctrl_if.slave host,
  input  logic [127:0]  prng_state_rd,
  output logic [31:0]   prng_state_wr,
  output logic [1:0]    prng_state_wr_valid,
  output logic          prng_hold
);
  localparam int IDX_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int NS    = 2 ** IDX_W;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       seed_q, seed_d;
  logic [1:0]        rsp_op_q, rsp_op_d;
  logic              rsp_ok_q, rsp_ok_d;
  logic [95:0]       slot_q [NS];
  logic [95:0]       slot_d [NS];
  logic [NS-1:0]     vld_q, vld_d;

  logic [95:0]       seed_words;
  logic [95:0]       src;
  logic [31:0]       src_x;
  logic [IDX_W-1:0]  cmd_idx;
  logic              in_range;

  prng_seed_expand u_expand (
    .seed  (seed_q),
    .words (seed_words)
  );

  assign cmd_idx  = host.cmd_slot[IDX_W-1:0];
  assign in_range = 32'(host.cmd_slot) < 32'(NSLOTS);
  assign src      = (op_q == OP_RESEED) ? seed_words : slot_q[idx_q];
  assign src_x    = src[31:0] ^ src[63:32] ^ src[95:64];

  assign host.cmd_ready = resetn && (state_q == ST_IDLE);
  assign host.rsp_valid = (state_q == ST_RESP);
  assign host.rsp_op    = rsp_op_q;
  assign host.rsp_ok    = rsp_ok_q;

  always_comb begin
    prng_state_wr       = '0;
    prng_state_wr_valid = WR_IDLE;
    prng_hold           = 1'b0;
    unique case (state_q)
      ST_W0: begin
        prng_state_wr       = src[31:0];
        prng_state_wr_valid = WR_S0;
        prng_hold           = 1'b1;
      end
      ST_W1: begin
        prng_state_wr       = src[63:32];
        prng_state_wr_valid = WR_S1;
        prng_hold           = 1'b1;
      end
      ST_W2: begin
        prng_state_wr       = src[95:64];
        prng_state_wr_valid = WR_S2;
        prng_hold           = 1'b1;
      end
      ST_CHECK: prng_hold = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    seed_d   = seed_q;
    rsp_op_d = rsp_op_q;
    rsp_ok_d = rsp_ok_q;
    slot_d   = slot_q;
    vld_d    = vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          op_d     = host.cmd_op;
          idx_d    = cmd_idx;
          seed_d   = host.cmd_seed;
          rsp_op_d = host.cmd_op;
          rsp_ok_d = 1'b0;
          state_d  = ST_RESP;
          unique case (host.cmd_op)
            OP_SAVE:
              if (in_range) state_d = ST_SAVE;
            OP_RESTORE:
              if (in_range && vld_q[cmd_idx]) state_d = ST_W0;
            OP_RESEED: state_d = ST_W0;
            default: ;
          endcase
        end
      end
      ST_SAVE: begin
        slot_d[idx_q] = prng_state_rd[127:32];
        vld_d[idx_q]  = 1'b1;
        rsp_ok_d      = 1'b1;
        state_d       = ST_RESP;
      end
      ST_W0: state_d = ST_W1;
      ST_W1: state_d = ST_W2;
      ST_W2: state_d = ST_CHECK;
      ST_CHECK: begin
        // Writes pre-empt sampling, so any difference is a real fault.
        rsp_ok_d = (prng_state_rd == {src, src_x});
        state_d  = ST_RESP;
      end
      ST_RESP:
        if (host.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      idx_q    <= '0;
      seed_q   <= '0;
      rsp_op_q <= '0;
      rsp_ok_q <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < NS; i++) slot_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      seed_q   <= seed_d;
      rsp_op_q <= rsp_op_d;
      rsp_ok_q <= rsp_ok_d;
      vld_q    <= vld_d;
      slot_q   <= slot_d;
    end
  end
endmodule

// File: tb/tb_prng_state_ctrl.sv
// Scoreboard bench for prng_state_ctrl with a small prng model.
// Responses are queued at issue and popped at the rsp handshake.
module tb_prng_state_ctrl;
  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] prng_state_rd;
  logic [31:0]  prng_state_wr;
  logic [1:0]   prng_state_wr_valid;
  logic         prng_hold;

  logic         prng_sample = 1'b0;
  logic         no_prng = 1'b0;
  logic [31:0]  m_s0 = 32'h1234_5678;
  logic [31:0]  m_s1 = 32'hCAFE_F00D;
  logic [31:0]  m_s2 = 32'h0BAD_BEEF;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] op;
    logic       ok;
  } rsp_t;
  rsp_t sb[$];

  prng_state_ctrl_if #(.SLOT_W(3)) bus ();

  prng_state_ctrl #(
    .NSLOTS (4),
    .SLOT_W (3)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .host                (bus.slave),
    .prng_state_rd       (prng_state_rd),
    .prng_state_wr       (prng_state_wr),
    .prng_state_wr_valid (prng_state_wr_valid),
    .prng_hold           (prng_hold)
  );

  always #5 clk = ~clk;

  assign prng_state_rd = no_prng ? 128'd0 :
    {m_s2, m_s1, m_s0, m_s0 ^ m_s1 ^ m_s2};

  always @(posedge clk) begin
    if (prng_state_wr_valid == 2'd1) m_s0 <= prng_state_wr;
    else if (prng_state_wr_valid == 2'd2) m_s1 <= prng_state_wr;
    else if (prng_state_wr_valid == 2'd3) m_s2 <= prng_state_wr;
    else if (prng_sample && !prng_hold) begin
      m_s0 <= m_s1;
      m_s1 <= m_s2;
      m_s2 <= m_s2 ^ (m_s2 << 5) ^ m_s0 ^ (m_s1 >> 3);
    end
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int n);
    prng_sample = 1'b1;
    repeat (n) step();
    prng_sample = 1'b0;
  endtask

  function automatic logic [95:0] exp_words(input logic [31:0] s);
    logic [31:0] a, b, c;
    a = s;
    b = s ^ 32'h9E37_79B9;
    c = s ^ 32'h7F4A_7C15;
    if (a < 32'd2)  a = a | 32'h2;
    if (b < 32'd8)  b = b | 32'h8;
    if (c < 32'd16) c = c | 32'h10;
    return {c, b, a};
  endfunction

  task automatic do_cmd(input logic [1:0]  op,
                        input logic [2:0]  slot,
                        input logic [31:0] seed,
                        input logic        ok,
                        input int          lat_exp,
                        input logic [95:0] wexp,
                        input int          nwr,
                        input int          stall);
    int   lat, wcnt, hold;
    bit   seen;
    rsp_t e;
    sb.push_back('{op: op, ok: ok});
    bus.cmd_op    = op;
    bus.cmd_slot  = slot;
    bus.cmd_seed  = seed;
    bus.cmd_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("cmd_ready", seen, 1);
    step();
    bus.cmd_valid = 1'b0;
    wcnt = 0;
    hold = 0;
    lat  = 1;
    while (!bus.rsp_valid && lat < 30) begin
      if (prng_hold) hold++;
      if (prng_state_wr_valid != 2'd0) begin
        check("wr_code", prng_state_wr_valid, wcnt + 1);
        if (wcnt < 3)
          check("wr_word", prng_state_wr, wexp[32*wcnt +: 32]);
        wcnt++;
      end
      step();
      lat++;
    end
    check("latency", lat, lat_exp);
    check("nwrites", wcnt, nwr);
    check("hold_cyc", hold, (nwr == 0) ? 0 : 4);
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("rsp_op", bus.rsp_op, e.op);
      check("rsp_ok", bus.rsp_ok, e.ok);
      for (int i = 0; i < stall; i++) begin
        step();
        check("rsp_stable",
              {bus.rsp_valid, bus.rsp_op, bus.rsp_ok},
              {1'b1, e.op, e.ok});
      end
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rsp_clr", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] saved, snap;
    logic [31:0]  nextv;
    resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_slot  = '0;
    bus.cmd_seed  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) step();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_op, bus.rsp_ok}, 0);
    check("rst_wr", {prng_state_wr, prng_state_wr_valid}, 0);
    check("rst_hold", prng_hold, 0);
    resetn = 1'b1;
    #1;
    check("cmd_ready_up", bus.cmd_ready, 1);

    do_cmd(2'd1, 3'd1, 0, 1'b0, 1, '0, 0, 0);

    do_cmd(2'd2, 3'd0, 0, 1'b1, 5,
           {32'h7F4A_7C15, 32'h9E37_79B9, 32'h2}, 3, 0);
    check("reseed_state", prng_state_rd,
          {32'h7F4A_7C15, 32'h9E37_79B9, 32'h2, 32'hE17D_05AE});

    do_cmd(2'd3, 3'd0, 0, 1'b0, 1, '0, 0, 3);
    do_cmd(2'd0, 3'd5, 0, 1'b0, 1, '0, 0, 3);

    do_cmd(2'd2, 3'd0, 32'd1, 1'b1, 5, exp_words(32'd1), 3, 0);
    do_cmd(2'd2, 3'd0, 32'h9E37_79BC, 1'b1, 5,
           {32'h7F4A_7C15 ^ 32'h9E37_79BC, 32'h0000_000D,
            32'h9E37_79BC}, 3, 0);
    do_cmd(2'd2, 3'd0, 32'h7F4A_7C16, 1'b1, 5,
           exp_words(32'h7F4A_7C16), 3, 0);

    sample(10);
    saved = prng_state_rd;
    do_cmd(2'd0, 3'd2, 0, 1'b1, 2, '0, 0, 0);
    sample(1);
    nextv = prng_state_rd[31:0];
    sample(4);
    check("state_moved", prng_state_rd != saved, 1);
    do_cmd(2'd1, 3'd2, 0, 1'b1, 5, saved[127:32], 3, 0);
    check("restored", prng_state_rd, saved);
    sample(1);
    check("next_value", prng_state_rd[31:0], nextv);

    no_prng = 1'b1;
    do_cmd(2'd2, 3'd0, 32'hDEAD_BEEF, 1'b0, 5,
           exp_words(32'hDEAD_BEEF), 3, 0);
    no_prng = 1'b0;

    do_cmd(2'd0, 3'd0, 0, 1'b1, 2, '0, 0, 0);
    bus.cmd_op    = 2'd2;
    bus.cmd_seed  = 32'd5;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("mid_w0", prng_state_wr_valid, 1);
    step();
    check("mid_w1", prng_state_wr_valid, 2);
    resetn = 1'b0;
    step();
    check("abort_wr", prng_state_wr_valid, 0);
    check("abort_hold", prng_hold, 0);
    check("abort_rsp", bus.rsp_valid, 0);
    check("abort_ready", bus.cmd_ready, 0);
    snap = prng_state_rd;
    resetn = 1'b1;
    #1;
    check("abort_ready_up", bus.cmd_ready, 1);
    repeat (2) step();
    check("abort_no_wr", prng_state_rd, snap);
    do_cmd(2'd1, 3'd0, 0, 1'b0, 1, '0, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
